// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto a CCFF chain and gates it with config_enable.
// Define CCFF_READBACK_VERIFY_EN to add the recirculating CRC readback check.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// LOAD   | accepting words, shifting bits into ccff_head
// VERIFY | recirculating the chain through ccff_tail, accumulating read CRC
// FINISH | one cycle: done pulse, CRC compare
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 256,
   parameter int WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              config_enable,
   output logic              config_readback,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int BW        = $clog2(CHAIN_LEN + 1);
   localparam int CW        = $clog2(WORD_W + 1);
   localparam int WCW       = $clog2(NWORDS + 1);

   localparam logic [BW-1:0]  LEN_B  = BW'(CHAIN_LEN);
   localparam logic [CW-1:0]  FULL_C = CW'(WORD_W);
   localparam logic [CW-1:0]  LAST_C = CW'(LAST_BITS);
   localparam logic [WCW-1:0] NW_B   = WCW'(NWORDS);

   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

   state_t            state;
   logic [WORD_W-1:0] hold, sr;
   logic [CW-1:0]     hold_cnt, sr_cnt;
   logic              hold_full;
   logic [WCW-1:0]    words;
   logic [BW-1:0]     bit_cnt;
   logic              head_q;

   logic              shift, sr_drain, accept, from_hold, direct, to_hold;
   logic              hold_full_n, ready_n;
   logic [WCW-1:0]    words_n;
   logic [BW-1:0]     bit_cnt_n;
   logic [CW-1:0]     accept_len;

   // The shift reg is refilled on the same edge its last bit goes out.
   assign shift       = (sr_cnt != '0);
   assign sr_drain    = (sr_cnt <= CW'(1));
   assign accept      = s_valid && s_ready;
   assign from_hold   = sr_drain && hold_full;
   assign direct      = sr_drain && !hold_full && accept;
   assign to_hold     = accept && !direct;
   assign hold_full_n = (hold_full && !sr_drain) || to_hold;
   assign words_n     = words + WCW'(accept);
   assign ready_n     = !hold_full_n && (words_n != NW_B);
   assign bit_cnt_n   = bit_cnt + BW'(shift);
   assign accept_len  = (words == NW_B - WCW'(1)) ? LAST_C : FULL_C;

`ifdef CCFF_READBACK_VERIFY_EN
   logic [15:0] crc_wr, crc_rd;
   logic        rb_q, err_q;

   function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign config_readback = rb_q;
   assign error           = err_q;
   assign ccff_head       = rb_q ? ccff_tail : head_q;
`else
   logic unused_tail;
   assign unused_tail     = ccff_tail;
   assign config_readback = 1'b0;
   assign error           = 1'b0;
   assign ccff_head       = head_q;
`endif

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state         <= IDLE;
         hold          <= '0;
         sr            <= '0;
         hold_cnt      <= '0;
         sr_cnt        <= '0;
         hold_full     <= 1'b0;
         words         <= '0;
         bit_cnt       <= '0;
         head_q        <= 1'b0;
         s_ready       <= 1'b0;
         config_enable <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
         crc_wr        <= 16'hFFFF;
         crc_rd        <= 16'hFFFF;
         rb_q          <= 1'b0;
         err_q         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done          <= 1'b0;
               busy          <= 1'b0;
               s_ready       <= 1'b0;
               config_enable <= 1'b0;
               head_q        <= 1'b0;
               if (start) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  s_ready   <= 1'b1;
                  bit_cnt   <= '0;
                  words     <= '0;
                  hold_full <= 1'b0;
                  sr_cnt    <= '0;
`ifdef CCFF_READBACK_VERIFY_EN
                  crc_wr    <= 16'hFFFF;
                  crc_rd    <= 16'hFFFF;
                  err_q     <= 1'b0;
`endif
               end
            end
            LOAD: begin
               head_q        <= shift ? sr[0] : 1'b0;
               config_enable <= shift;
`ifdef CCFF_READBACK_VERIFY_EN
               if (shift) crc_wr <= crc_next(crc_wr, sr[0]);
`endif
               if (from_hold) begin
                  sr     <= hold;
                  sr_cnt <= hold_cnt;
               end else if (direct) begin
                  sr     <= s_data;
                  sr_cnt <= accept_len;
               end else if (shift) begin
                  sr     <= {1'b0, sr[WORD_W-1:1]};
                  sr_cnt <= sr_cnt - CW'(1);
               end
               if (to_hold) begin
                  hold     <= s_data;
                  hold_cnt <= accept_len;
               end
               hold_full <= hold_full_n;
               words     <= words_n;
               s_ready   <= ready_n;
               bit_cnt   <= bit_cnt_n;
               if (bit_cnt_n == LEN_B) begin
                  s_ready <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
                  state   <= VERIFY;
                  bit_cnt <= '0;
`else
                  state   <= FINISH;
`endif
               end
            end
            VERIFY: begin
`ifdef CCFF_READBACK_VERIFY_EN
               if (rb_q) crc_rd <= crc_next(crc_rd, ccff_tail);
               rb_q          <= 1'b1;
               config_enable <= 1'b1;
               head_q        <= 1'b0;
               bit_cnt       <= bit_cnt_n + BW'(1);
               if (bit_cnt == LEN_B - BW'(1)) state <= FINISH;
`else
               state <= FINISH;
`endif
            end
            FINISH: begin
`ifdef CCFF_READBACK_VERIFY_EN
               // Last recirculated bit is still on ccff_tail this cycle.
               err_q <= (crc_next(crc_rd, ccff_tail) != crc_wr);
               rb_q  <= 1'b0;
`endif
               config_enable <= 1'b0;
               head_q        <= 1'b0;
               done          <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader against an ideal chain model; covers
// the readback path when CCFF_READBACK_VERIFY_EN is defined.
module tb_ccff_chain_loader;

   localparam int L  = 40;
   localparam int W  = 32;
   localparam int NW = 2;
`ifdef CCFF_READBACK_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic         prog_clk = 1'b0;
   logic         pReset;
   logic         start;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_ready, ccff_head, ccff_tail, config_enable, config_readback;
   logic         busy, done, error;

   ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail),
      .config_enable(config_enable), .config_readback(config_readback),
      .busy(busy), .done(done), .error(error)
   );

   always #5 prog_clk = ~prog_clk;

   // Ideal chain: head enters bit 0, tail is bit L-1.
   logic [L-1:0] chain = '0;
   int           rb_idx = 0;
   int           flip_at = -1;

   always @(posedge prog_clk) begin
      if (config_enable) chain <= {chain[L-2:0], ccff_head};
      rb_idx <= config_readback ? rb_idx + 1 : 0;
   end

   assign ccff_tail = chain[L-1] ^ (config_readback && (rb_idx == flip_at));

   int          total = 0, bad = 0;
   int          cyc = 0, t_start = 0, t_done = 0;
   int          wr_n, idle, pend, head_idle_hi, acc_cnt, done_cnt, rb_n, rb_mis;
   bit          seen;
   logic        err_at_done;
   logic [63:0] wr_bits;

   always @(posedge prog_clk) begin
      if (pReset || (start && !busy)) begin
         wr_n = 0; idle = 0; pend = 0; head_idle_hi = 0; acc_cnt = 0;
         done_cnt = 0; rb_n = 0; rb_mis = 0; seen = 0; wr_bits = '0;
         err_at_done = 1'b0;
         if (!pReset) t_start = cyc;
      end else begin
         if (done) begin
            done_cnt++;
            t_done = cyc - 1;
            err_at_done = error;
         end
         if (s_valid && s_ready) acc_cnt++;
         if (config_enable && !config_readback) begin
            if (wr_n < 64) wr_bits[wr_n] = ccff_head;
            wr_n++;
            if (seen) idle += pend;
            pend = 0;
            seen = 1;
         end else if (!config_enable && seen && wr_n < L) begin
            pend++;
         end
         if (!config_enable && ccff_head) head_idle_hi++;
         if (config_readback) begin
            rb_n++;
            if (ccff_head != ccff_tail) rb_mis++;
         end
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int tmo = 0;
      while (!s_ready && tmo < 300) begin
         @(negedge prog_clk);
         tmo++;
      end
      if (tmo >= 300) chk(tag, 64'(s_ready), 64'd1);
   endtask

   task automatic run(input logic [W-1:0] w0, input logic [W-1:0] w1,
                      input int gap, input bit extra, input bit mid, input int flip);
      logic [W-1:0] w[NW];
      logic [63:0]  exp_s, exp_c;
      int           exp_idle, tmo;
      w[0] = w0; w[1] = w1;
      exp_s = '0; exp_c = '0;
      for (int k = 0; k < L; k++) begin
         exp_s[k]       = w[k / W][k % W];
         exp_c[L-1-k]   = w[k / W][k % W];
      end
      exp_idle = (gap + 1 > W) ? gap + 1 - W : 0;
      flip_at  = flip;

      @(negedge prog_clk); start = 1'b1;
      @(negedge prog_clk); start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("ready_after_start", 64'(s_ready), 64'd1);
      chk("error_cleared", 64'(error), 64'd0);

      for (int i = 0; i < NW; i++) begin
         s_data  = w[i];
         s_valid = 1'b1;
         wait_ready("accept_timeout");
         @(negedge prog_clk);
         if (i == NW - 1 && extra) begin
            s_data = $urandom;
         end else begin
            s_valid = 1'b0;
         end
         if (i == 0 && mid) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
         end
         if (i == 0) repeat (gap) @(negedge prog_clk);
      end

      tmo = 0;
      while (done_cnt == 0 && tmo < 400) begin
         @(negedge prog_clk);
         tmo++;
      end
      chk("done_seen", 64'(done_cnt > 0), 64'd1);
      repeat (2) @(negedge prog_clk);
      s_valid = 1'b0;

      chk("stream", wr_bits, exp_s);
      chk("shift_count", 64'(wr_n), 64'(L));
      chk("idle_cycles", 64'(idle), 64'(exp_idle));
      chk("head_when_gated", 64'(head_idle_hi), 64'd0);
      chk("words_accepted", 64'(acc_cnt), 64'(NW));
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("done_latency", 64'(t_done - t_start), 64'(L + 2 + exp_idle + VER * L));
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("readback_cycles", 64'(rb_n), 64'(VER * L));
      chk("recirc_mux", 64'(rb_mis), 64'd0);
      chk("error_at_done", 64'(err_at_done), 64'(VER != 0 && flip >= 0));
      if (flip < 0) chk("chain_contents", 64'(chain), exp_c);
      flip_at = -1;
   endtask

   initial begin
      pReset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(negedge prog_clk);
      chk("reset_outputs", 64'({s_ready, ccff_head, config_enable, config_readback,
                                busy, done, error}), 64'd0);
      pReset = 1'b0;
      @(negedge prog_clk);

      run(32'hFFFF_FFFF, 32'h0000_00C3, 0, 1'b1, 1'b1, -1);
      chk("tail_bits", wr_bits[39:32], 64'hC3);
      run($urandom, $urandom, 0, 1'b0, 1'b0, -1);
      run($urandom, $urandom, 0, 1'b1, 1'b0, -1);
      run($urandom, $urandom, W + 4, 1'b0, 1'b0, -1);
      run($urandom, $urandom, W + 1 + int'($urandom_range(0, 3)), 1'b0, 1'b0, -1);
`ifdef CCFF_READBACK_VERIFY_EN
      run($urandom, $urandom, 0, 1'b0, 1'b0, int'($urandom_range(0, L - 1)));
      repeat (4) @(negedge prog_clk);
      chk("error_sticky", 64'(error), 64'd1);
      run($urandom, $urandom, 0, 1'b0, 1'b0, -1);
`endif

      // Asynchronous reset in the middle of a load.
      @(negedge prog_clk); start = 1'b1;
      @(negedge prog_clk); start = 1'b0;
      s_data = $urandom; s_valid = 1'b1;
      wait_ready("rst_accept0");
      @(negedge prog_clk);
      s_data = $urandom;
      wait_ready("rst_accept1");
      @(negedge prog_clk);
      s_valid = 1'b0;
      for (int t = 0; t < 100 && wr_n < 20; t++) @(negedge prog_clk);
      chk("bits_before_reset", 64'(wr_n >= 20), 64'd1);
      #2 pReset = 1'b1;
      #1 chk("async_reset_outputs", 64'({s_ready, ccff_head, config_enable,
                                          config_readback, busy, done, error}), 64'd0);
      @(negedge prog_clk);
      pReset = 1'b0;
      run($urandom, $urandom, 0, 1'b0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
